// File: rtl/traffic_fsm_if.sv
// rtl/traffic_fsm_if.sv - signal bundle between the traffic controller and its lamps, sensors and interval timer
interface traffic_fsm_if;
  logic       Walking_Register;
  logic       Traffic_Sensor;
  logic       Expired;
  logic       Walking_Register_reset;
  logic       Start_Timer;
  logic [6:0] Traffic_Lights;

  // master: the controller, which drives the lamps and restarts the timer
  modport master (
    input  Walking_Register,
    input  Traffic_Sensor,
    input  Expired,
    output Walking_Register_reset,
    output Start_Timer,
    output Traffic_Lights
  );

  // slave: the intersection environment (walk latch, vehicle sensor, timer)
  modport slave (
    output Walking_Register,
    output Traffic_Sensor,
    output Expired,
    input  Walking_Register_reset,
    input  Start_Timer,
    input  Traffic_Lights
  );
endinterface

// File: rtl/traffic_fsm.sv
// rtl/traffic_fsm.sv - main/side street traffic light controller with pedestrian walk phase
module traffic_fsm (
  input  logic          clock,
  input  logic          reset,
  traffic_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_MG1  = 3'd0,
    S_MG2  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG1  = 3'd4,
    S_SG2  = 3'd5,
    S_SY   = 3'd6
  } state_t;

  localparam logic [6:0] LAMP_MAIN_GO   = 7'h18;
  localparam logic [6:0] LAMP_MAIN_WARN = 7'h28;
  localparam logic [6:0] LAMP_WALK      = 7'h49;
  localparam logic [6:0] LAMP_SIDE_GO   = 7'h42;
  localparam logic [6:0] LAMP_SIDE_WARN = 7'h44;

  state_t     state;
  state_t     next_state;
  logic       illegal;
  logic       qualified;
  logic [6:0] lights_d;
  logic       start_d;
  logic       wr_reset_d;

  // The timer restart pulse also masks Expired, so a stale expiry from the
  // previous interval can never cause a second back-to-back transition.
  assign qualified = bus.Expired & ~bus.Start_Timer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                      <= S_MG1;
      bus.Traffic_Lights         <= LAMP_MAIN_GO;
      bus.Start_Timer            <= 1'b1;
      bus.Walking_Register_reset <= 1'b0;
    end else begin
      state                      <= next_state;
      bus.Traffic_Lights         <= lights_d;
      bus.Start_Timer            <= start_d;
      bus.Walking_Register_reset <= wr_reset_d;
    end
  end

  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    case (state)
      S_MG1:  if (qualified) next_state = bus.Traffic_Sensor ? S_MY : S_MG2;
      S_MG2:  if (qualified) next_state = S_MY;
      S_MY:   if (qualified) next_state = bus.Walking_Register ? S_WALK : S_SG1;
      S_WALK: if (qualified) next_state = S_SG1;
      S_SG1:  if (qualified) next_state = bus.Traffic_Sensor ? S_SG2 : S_SY;
      S_SG2:  if (qualified) next_state = S_SY;
      S_SY:   if (qualified) next_state = S_MG1;
      default: begin
        next_state = S_MG1;
        illegal    = 1'b1;
      end
    endcase
  end

  // Outputs are computed from the next state and registered alongside it,
  // so the lamps change on the same edge as the state with no input path.
  always_comb begin
    lights_d   = LAMP_MAIN_GO;
    start_d    = illegal || (next_state != state);
    wr_reset_d = (next_state == S_WALK) && (state != S_WALK);
    case (next_state)
      S_MG1, S_MG2: lights_d = LAMP_MAIN_GO;
      S_MY:         lights_d = LAMP_MAIN_WARN;
      S_WALK:       lights_d = LAMP_WALK;
      S_SG1, S_SG2: lights_d = LAMP_SIDE_GO;
      S_SY:         lights_d = LAMP_SIDE_WARN;
      default:      lights_d = LAMP_MAIN_GO;
    endcase
  end

endmodule

// File: tb/tb_traffic_fsm.sv
// tb/tb_traffic_fsm.sv - directed bench for traffic_fsm with a cycle-level reference model
module tb_traffic_fsm;

  logic clock;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  traffic_fsm_if bus ();

  traffic_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: phases by name, with a lamp lookup table.
  localparam int MG1 = 0, MG2 = 1, MY = 2, WALK = 3, SG1 = 4, SG2 = 5, SY = 6;
  logic [6:0] lamp_tbl [7] = '{7'h18, 7'h18, 7'h28, 7'h49, 7'h42, 7'h42, 7'h44};

  int m_phase;
  bit m_restart;
  bit m_clear_walk;

  function automatic int successor(input int p, input bit walk, input bit car);
    case (p)
      MG1:     return car ? MY : MG2;
      MG2:     return MY;
      MY:      return walk ? WALK : SG1;
      WALK:    return SG1;
      SG1:     return car ? SG2 : SY;
      SG2:     return SY;
      default: return MG1;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase      <= MG1;
      m_restart    <= 1'b1;
      m_clear_walk <= 1'b0;
    end else if (bus.Expired && !m_restart) begin
      m_phase      <= successor(m_phase, bus.Walking_Register, bus.Traffic_Sensor);
      m_restart    <= 1'b1;
      m_clear_walk <= (successor(m_phase, bus.Walking_Register, bus.Traffic_Sensor) == WALK);
    end else begin
      m_restart    <= 1'b0;
      m_clear_walk <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
  endtask

  function automatic logic [8:0] dut_out();
    return {bus.Traffic_Lights, bus.Start_Timer, bus.Walking_Register_reset};
  endfunction

  always @(negedge clock) begin
    check("model", dut_out(), {lamp_tbl[m_phase], m_restart, m_clear_walk});
    check("safety", {8'd0, ((bus.Traffic_Lights[4] & bus.Traffic_Lights[1]) |
                            (bus.Traffic_Lights[0] & ~(bus.Traffic_Lights[6] & bus.Traffic_Lights[3])))},
          9'd0);
  end

  // Raise Expired with the given branch inputs and return once a transition pulse is seen.
  task automatic expire(input bit walk, input bit car);
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    bus.Walking_Register = walk;
    bus.Traffic_Sensor   = car;
    bus.Expired          = 1'b1;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(negedge clock);
      seen = bus.Start_Timer;
    end
    if (!seen) check("expire_timeout", 9'd0, 9'd1);
    bus.Expired          = 1'b0;
    bus.Walking_Register = 1'b0;
    bus.Traffic_Sensor   = 1'b0;
  endtask

  logic [6:0] step_lamps [11] = '{7'h18, 7'h18, 7'h18, 7'h18, 7'h28, 7'h28,
                                  7'h42, 7'h42, 7'h44, 7'h44, 7'h18};

  initial begin
    int  pulses;
    bit  prev_st;
    bit  back_to_back;

    reset                = 1'b0;
    bus.Walking_Register = 1'b0;
    bus.Traffic_Sensor   = 1'b0;
    bus.Expired          = 1'b0;

    repeat (2) begin
      @(negedge clock);
      check("in_reset", dut_out(), {7'h18, 1'b1, 1'b0});
    end
    reset       = 1'b1;
    bus.Expired = 1'b1;

    // Expired toggling every cycle: each phase lasts two cycles.
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      check($sformatf("toggle_%0d", k), dut_out(),
            {step_lamps[k], (k >= 2 && (k % 2) == 0), 1'b0});
      bus.Expired = ~bus.Expired;
    end
    bus.Expired = 1'b0;

    expire(1'b0, 1'b1);
    check("mg1_car_to_my", dut_out(), {7'h28, 1'b1, 1'b0});
    expire(1'b1, 1'b0);
    check("my_walk_entry", dut_out(), {7'h49, 1'b1, 1'b1});
    @(negedge clock);
    check("walk_hold", dut_out(), {7'h49, 1'b0, 1'b0});
    expire(1'b0, 1'b0);
    check("walk_to_sg1", dut_out(), {7'h42, 1'b1, 1'b0});
    expire(1'b0, 1'b1);
    check("sg1_car_to_sg2", dut_out(), {7'h42, 1'b1, 1'b0});
    @(negedge clock);
    check("sg2_hold", dut_out(), {7'h42, 1'b0, 1'b0});

    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("async_reset_sg2", dut_out(), {7'h18, 1'b1, 1'b0});
    repeat (2) @(negedge clock);

    // Expired held high: a transition on every other edge, never two in a row.
    reset        = 1'b1;
    bus.Expired  = 1'b1;
    pulses       = 0;
    prev_st      = 1'b1;
    back_to_back = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (bus.Start_Timer) begin
        pulses++;
        if (prev_st && k > 0) back_to_back = 1'b1;
      end
      prev_st = bus.Start_Timer;
    end
    check("held_pulses", 9'(pulses), 9'd6);
    check("held_no_back_to_back", {8'd0, back_to_back}, 9'd0);
    check("held_end_lamps", {2'b0, bus.Traffic_Lights}, 9'h018);

    // Mixed pattern: branch inputs wiggle while the timer mostly idles.
    bus.Expired = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      bus.Expired          = ((i % 5) == 1);
      bus.Walking_Register = ((i / 2) % 2) == 1;
      bus.Traffic_Sensor   = ((i / 4) % 2) == 1;
    end
    @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 The block SHALL have no parameters; all timing comes from an external interval timer.
REQ-002 clock  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 Walking_Register  input  1  latched pedestrian walk request; 1 = request pending.
REQ-005 Traffic_Sensor  input  1  side-street vehicle present; 1 = present.
REQ-006 Expired  input  1  external timer interval elapsed; 1 = expired.
REQ-007 Walking_Register_reset  output  1  one-cycle pulse that clears the external walk-request latch.
REQ-008 Start_Timer  output  1  one-cycle pulse that restarts the external timer.
REQ-009 Traffic_Lights  output  7  lamp drive, one-hot per lamp group: [6] main R, [5] main Y, [4] main G, [3] side R, [2] side Y, [1] side G, [0] walk.

Function
REQ-010 The block SHALL be a Moore FSM with all outputs driven from registers, with no combinational input-to-output path.
REQ-011 The states SHALL be MG1, MG2, MY, WALK, SG1, SG2 and SY.
REQ-012 Traffic_Lights SHALL be 7'h18 in MG1 and MG2, 7'h28 in MY, 7'h49 in WALK, 7'h42 in SG1 and SG2, and 7'h44 in SY.
REQ-013 An Expired sample SHALL be qualified only on a rising edge where Start_Timer is 0; Expired=1 while Start_Timer=1 SHALL be ignored, with no state change.
REQ-014 On a qualified Expired=1, MG1 SHALL go to MY if Traffic_Sensor=1, otherwise to MG2.
REQ-015 On a qualified Expired=1, MG2 SHALL go to MY.
REQ-016 On a qualified Expired=1, MY SHALL go to WALK if Walking_Register=1, otherwise to SG1.
REQ-017 On a qualified Expired=1, WALK SHALL go to SG1.
REQ-018 On a qualified Expired=1, SG1 SHALL go to SG2 if Traffic_Sensor=1, otherwise to SY.
REQ-019 On a qualified Expired=1, SG2 SHALL go to SY.
REQ-020 On a qualified Expired=1, SY SHALL go to MG1.
REQ-021 With Expired=0, every state SHALL hold; Walking_Register and Traffic_Sensor SHALL have no effect outside the branch points in REQ-014, REQ-016 and REQ-018.
REQ-022 Start_Timer SHALL be 1 for exactly the one cycle following every state transition and 0 otherwise.
REQ-023 Walking_Register_reset SHALL be 1 for exactly the one cycle following entry to WALK, coincident with that Start_Timer pulse, and 0 otherwise.
REQ-024 Traffic_Lights SHALL update on the same edge as the state register, i.e. zero cycles of extra latency.
REQ-025 Any unreachable or illegal state encoding SHALL go to MG1 on the next edge, with Start_Timer=1.
REQ-026 Main green and side green SHALL never be asserted together in any state, and walk SHALL be asserted only with both reds.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force state MG1, Traffic_Lights=7'h18, Start_Timer=1 and Walking_Register_reset=0.
REQ-028 On the first rising edge after reset goes to 1, Start_Timer SHALL go to 0 and the state SHALL remain MG1; Expired SHALL be ignored on that edge per REQ-013.
REQ-029 Assertion of reset in any state, mid-interval, SHALL abort the cycle immediately and apply REQ-027.

Verification
REQ-030 Hold reset=0 for 2 cycles, then release -> during reset lights=7'h18 and Start_Timer=1; one cycle after release Start_Timer=0, state MG1.
REQ-031 After reset release, hold Walking_Register=0 and Traffic_Sensor=0 and toggle Expired 1/0 every cycle -> lights step 18, 18, 28, 42, 44, 18 (MG1, MG2, MY, SG1, SY, MG1), with each state held 2 cycles and Start_Timer pulsing on each entry.
REQ-032 Walking_Register=1 at MY expiry -> WALK with lights=7'h49 and Walking_Register_reset=1 plus Start_Timer=1 for one cycle, then SG1 (7'h42) on the next qualified expiry.
REQ-033 Traffic_Sensor=1 at MG1 expiry -> direct to MY (7'h28), skipping MG2; Traffic_Sensor=1 at SG1 expiry -> SG2 (7'h42 held one more interval) before SY.
REQ-034 Expired held at 1 continuously -> exactly one transition every 2 cycles and never two consecutive transitions.
REQ-035 Drive reset=0 while in SG2 -> outputs go to 7'h18 and Start_Timer=1 asynchronously, before the next clock edge.
